// File: rtl/shift_ctrl_if.sv
// Command channel of the shift-register sequencer: valid/ready handshake
// carrying op code, data byte and repeat count.
interface shift_ctrl_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_data;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_cnt,
    output cmd_ready
  );

endinterface

// File: rtl/shift_ctrl.sv
// Command sequencer for the 8-bit multi-mode shift register.
// Repeats shift/rotate ops, serialises a byte MSB first for serial load and
// holds the register (sel=001, data_in=reg_q) whenever no command runs.
// Optional feature macro: SHIFT_CTRL_ABORT_EN adds the cmd_abort input.
module shift_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  shift_ctrl_if.slave cmd,
`ifdef SHIFT_CTRL_ABORT_EN
  input  logic       cmd_abort,
`endif
  input  logic [7:0] reg_q,
  output logic [2:0] sel,
  output logic [7:0] data_in,
  output logic       cin,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_CLR   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SER   = 3'b101;
  localparam logic [2:0] SEL_HOLD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SER  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       sel_d;
  logic             cin_d;
  logic             busy_d;
  logic             done_d;
  logic             abort_c;

`ifdef SHIFT_CTRL_ABORT_EN
  assign abort_c = cmd_abort;
`else
  assign abort_c = 1'b0;
`endif

  // Ready only in IDLE and never while reset is asserted.
  assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;

  // Hold path reloads the register's own output; otherwise drive latched data.
  assign data_in = (state_q == ST_IDLE) ? reg_q : data_q;

  // State, latched command fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sel     <= SEL_HOLD;
      cin     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sel     <= sel_d;
      cin     <= cin_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; idle hold is the default.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sel_d   = SEL_HOLD;
    cin_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          data_d = cmd.cmd_data;
          cnt_d  = cmd.cmd_cnt;
          case (cmd.cmd_op)
            OP_CLR, OP_LOAD: begin
              // Single-cycle ops: the count field is ignored.
              cnt_d   = CNT_W'(1);
              state_d = ST_RUN;
              sel_d   = cmd.cmd_op;
              busy_d  = 1'b1;
            end
            OP_SER: begin
              state_d = ST_SER;
              bit_d   = 3'd7;
              sel_d   = OP_SER;
              cin_d   = cmd.cmd_data[7];
              busy_d  = 1'b1;
            end
            default: begin
              if (cmd.cmd_cnt == '0) begin
                // Zero repeats: stay held and complete immediately.
                done_d = 1'b1;
              end else begin
                state_d = ST_RUN;
                sel_d   = cmd.cmd_op;
                busy_d  = 1'b1;
              end
            end
          endcase
        end
      end

      ST_RUN: begin
        if (abort_c || (cnt_q == CNT_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          sel_d  = op_q;
          busy_d = 1'b1;
        end
      end

      ST_SER: begin
        if (abort_c || (bit_q == 3'd0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          bit_d  = bit_q - 3'd1;
          sel_d  = OP_SER;
          cin_d  = data_q[bit_q - 3'd1];
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Testbench for shift_ctrl: a behavioural shift register closes the loop on
// reg_q, a per-cycle queue model predicts the controller outputs, directed
// scenarios pin literal results and a random phase exercises the rest.
module tb_shift_ctrl;

  localparam int unsigned CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_q = 8'h00;
  logic [7:0] data_in;
  logic [2:0] sel;
  logic       cin;
  logic       busy;
  logic       done;
`ifdef SHIFT_CTRL_ABORT_EN
  logic       cmd_abort;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_ctrl_if #(.CNT_W(CNT_W)) cmd ();

  shift_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
`ifdef SHIFT_CTRL_ABORT_EN
    .cmd_abort(cmd_abort),
`endif
    .reg_q    (reg_q),
    .sel      (sel),
    .data_in  (data_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done)
  );

  // Behavioural 8-bit multi-mode shift register driven by the controller.
  always @(posedge clk) begin
    case (sel)
      3'b000: reg_q <= 8'h00;
      3'b001: reg_q <= data_in;
      3'b010: reg_q <= reg_q >> 1;
      3'b011: reg_q <= reg_q << 1;
      3'b100: reg_q <= {reg_q[7], reg_q[7:1]};
      3'b101: reg_q <= {reg_q[6:0], cin};
      3'b110: reg_q <= {reg_q[0], reg_q[7:1]};
      default: reg_q <= {reg_q[6:0], reg_q[7]};
    endcase
  end

  // Reference model: a queue of expected per-cycle outputs for the command.
  typedef struct packed {
    logic [2:0] sel;
    logic       cin;
    logic       busy;
    logic       done;
  } cyc_t;

  localparam cyc_t IDLE_C = '{3'b001, 1'b0, 1'b0, 1'b0};
  localparam cyc_t DONE_C = '{3'b001, 1'b0, 1'b0, 1'b1};

  cyc_t       cur = IDLE_C;
  cyc_t       pend[$];
  logic [7:0] m_data = 8'h00;
  bit         m_live = 1'b0;
  logic       abort_now;

`ifdef SHIFT_CTRL_ABORT_EN
  assign abort_now = cmd_abort;
`else
  assign abort_now = 1'b0;
`endif

  function automatic void m_start(input logic [2:0] op, input logic [7:0] d,
                                  input logic [CNT_W-1:0] c);
    int   n;
    cyc_t e;
    pend.delete();
    m_data = d;
    if (op == 3'b000 || op == 3'b001) n = 1;
    else if (op == 3'b101) n = 8;
    else n = int'(c);
    for (int i = 0; i < n; i++) begin
      e.sel  = op;
      e.busy = 1'b1;
      e.done = 1'b0;
      e.cin  = (op == 3'b101) ? d[7-i] : 1'b0;
      pend.push_back(e);
    end
    pend.push_back(DONE_C);
    cur = pend.pop_front();
  endfunction

  // Advance the model one cycle from the inputs seen at this edge.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      cur    = IDLE_C;
      m_live = 1'b1;
    end else if (!cur.busy && cmd.cmd_valid) begin
      m_start(cmd.cmd_op, cmd.cmd_data, cmd.cmd_cnt);
    end else if (cur.busy && abort_now) begin
      pend.delete();
      cur = DONE_C;
    end else if (pend.size() > 0) begin
      cur = pend.pop_front();
    end else begin
      cur = IDLE_C;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model each cycle, away from the edge.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("sel",       8'(sel),           8'(cur.sel));
      chk("cin",       8'(cin),           8'(cur.cin));
      chk("busy",      8'(busy),          8'(cur.busy));
      chk("done",      8'(done),          8'(cur.done));
      chk("cmd_ready", 8'(cmd.cmd_ready), 8'(!cur.busy && !rst));
      chk("data_in",   data_in,           cur.busy ? m_data : reg_q);
    end
  end

  // Issue one command and follow it until done, bounded by a cycle budget.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d,
                         input logic [CNT_W-1:0] c,
                         output int ncyc, output int nbusy, output logic [7:0] cseq);
    ncyc  = 0;
    nbusy = 0;
    cseq  = 8'h00;
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_data  = d;
    cmd.cmd_cnt   = c;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) cmd.cmd_valid = 1'b0;
      if (busy) begin
        nbusy++;
        cseq = {cseq[6:0], cin};
      end
      if (done) begin
        ncyc = i;
        break;
      end
    end
    if (ncyc == 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: op %b got no done within 40 cycles", op);
    end
  endtask

  task automatic load(input logic [7:0] d);
    int         a, b;
    logic [7:0] s;
    run_cmd(3'b001, d, '0, a, b, s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int         ncyc, nbusy;
    logic [7:0] cseq;

    rst           = 1'b1;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = 3'b000;
    cmd.cmd_data  = 8'h00;
    cmd.cmd_cnt   = '0;
`ifdef SHIFT_CTRL_ABORT_EN
    cmd_abort     = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",   8'(sel),           8'h01);
    chk("rst_busy",  8'(busy),          8'h00);
    chk("rst_done",  8'(done),          8'h00);
    chk("rst_ready", 8'(cmd.cmd_ready), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 8'(cmd.cmd_ready), 8'h01);

    // Load then logical right by 3
    run_cmd(3'b001, 8'hB4, 4'd9, ncyc, nbusy, cseq);
    chk("load_busy", 8'(nbusy), 8'd1);
    chk("load_q",    reg_q,     8'hB4);
    run_cmd(3'b010, 8'h00, 4'd3, ncyc, nbusy, cseq);
    chk("lsr3_busy", 8'(nbusy), 8'd3);
    chk("lsr3_cyc",  8'(ncyc),  8'd4);
    chk("lsr3_q",    reg_q,     8'h16);
    @(posedge clk);
    #1;
    chk("lsr3_done_once", 8'(done), 8'h00);

    // Rotate left by 4, arithmetic right by 2
    load(8'hB4);
    run_cmd(3'b111, 8'h00, 4'd4, ncyc, nbusy, cseq);
    chk("rol4_q", reg_q, 8'h4B);
    load(8'h90);
    run_cmd(3'b100, 8'h00, 4'd2, ncyc, nbusy, cseq);
    chk("asr2_q", reg_q, 8'hE4);

    // Serial load of 0xA5
    run_cmd(3'b101, 8'hA5, 4'd0, ncyc, nbusy, cseq);
    chk("ser_busy", 8'(nbusy), 8'd8);
    chk("ser_cin",  cseq,      8'hA5);
    chk("ser_cyc",  8'(ncyc),  8'd9);
    chk("ser_q",    reg_q,     8'hA5);

    // Zero-count rotate and idle hold
    load(8'h3C);
    run_cmd(3'b110, 8'h00, 4'd0, ncyc, nbusy, cseq);
    chk("cnt0_busy", 8'(nbusy), 8'd0);
    chk("cnt0_cyc",  8'(ncyc),  8'd1);
    chk("cnt0_q",    reg_q,     8'h3C);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_q", reg_q, 8'h3C);

    // Reset on cycle 2 of shift-left by 5
    load(8'h01);
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = 3'b011;
    cmd.cmd_cnt   = 4'd5;
    @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_done", 8'(done), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 8'(cmd.cmd_ready), 8'h01);
    chk("rst_mid_q",     reg_q,             8'h04);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_hold", reg_q, 8'h04);

`ifdef SHIFT_CTRL_ABORT_EN
    // Abort on cycle 3 of shift-left by 6
    load(8'h01);
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = 3'b011;
    cmd.cmd_cnt   = 4'd6;
    @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done", 8'(done), 8'h01);
    chk("abort_sel",  8'(sel),  8'h01);
    @(negedge clk);
    cmd_abort = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_q", reg_q, 8'h08);
`endif

    // Random traffic: commands while busy, back-to-back, resets and aborts
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cmd.cmd_valid = ($urandom_range(0, 2) == 0);
      cmd.cmd_op    = 3'($urandom_range(0, 7));
      cmd.cmd_data  = 8'($urandom_range(0, 255));
      cmd.cmd_cnt   = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
      rst           = ($urandom_range(0, 99) == 0);
`ifdef SHIFT_CTRL_ABORT_EN
      cmd_abort     = ($urandom_range(0, 15) == 0);
`endif
    end
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    rst           = 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
    cmd_abort     = 1'b0;
`endif
    repeat (20) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
